// File: rtl/prog_mem_pkg.sv
// Shared types and helpers for the field-loadable program memory.
// Holds the loader state encoding, the default fill word and the beats-per-word calculation.
package prog_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [5:0] FILL_DEFAULT = 6'h3F;

  // Number of load-port chunks needed to cover one instruction word.
  function automatic int beats(input int instr_w, input int load_w);
    return (instr_w + load_w - 1) / load_w;
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Instruction storage with a per-entry valid vector.
// One synchronous write port, one combinational read port, and a clear-all for the valid bits.
module prog_mem_array #(
  parameter int DEPTH   = 32,
  parameter int INSTR_W = 6,
  parameter int AW      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata,
  output logic               rvalid
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   valid_reg;

  // Contents are never reset; the valid bits alone decide what is visible.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
          valid_reg[gi] <= 1'b0;
        end else if (we && (waddr == AW'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign rdata  = mem[raddr];
  assign rvalid = valid_reg[raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// Field-loadable instruction memory: packs chunked load-port data into words,
// writes them sequentially, and serves zero-latency CPU fetches while holding the CPU during a load.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int                 ADDR_W  = 8,
  parameter int                 INSTR_W = 6,
  parameter int                 DEPTH   = 32,
  parameter int                 LOAD_W  = 4,
  parameter logic [INSTR_W-1:0] FILL    = INSTR_W'(FILL_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          address,
  output logic [INSTR_W-1:0]         instruction,
  input  logic                       ld_start,
  input  logic                       ld_valid,
  input  logic [LOAD_W-1:0]          ld_data,
  input  logic                       ld_end,
  output logic                       ld_ready,
  output logic                       cpu_hold,
  output logic [$clog2(DEPTH+1)-1:0] prog_len,
  output logic                       overflow
);

  localparam int BEATS  = beats(INSTR_W, LOAD_W);
  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t               state_reg, state_next;
  logic [LEN_W-1:0]     wr_ptr_reg;
  logic [BEAT_W-1:0]    beat_reg;
  logic [INSTR_W-1:0]   asm_reg;
  logic [INSTR_W-1:0]   asm_next;
  logic                 overflow_reg;
  logic                 loading;
  logic                 fire;
  logic                 last_beat;
  logic                 word_we;
  logic                 mem_full;
  logic [INSTR_W-1:0]   rd_word;
  logic                 rd_valid;

  assign loading   = (state_reg == LOAD);
  // A start pulse wins over a coincident chunk, so the chunk is dropped.
  assign fire      = ld_valid && loading && !ld_start;
  assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));
  assign word_we   = fire && last_beat;
  assign mem_full  = (wr_ptr_reg == LEN_W'(DEPTH));
  // Only the low INSTR_W bits of the assembled value survive, so the shifter is kept word-wide.
  assign asm_next  = INSTR_W'({asm_reg, ld_data});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ld_start) state_next = LOAD;
      end
      LOAD: begin
        if (ld_start) begin
          state_next = LOAD;
        end else if (ld_end) begin
          state_next = IDLE;
        end else if (word_we && (wr_ptr_reg == LEN_W'(DEPTH - 1))) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // wr_ptr doubles as the program length: both count words written since the last start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      beat_reg     <= '0;
      asm_reg      <= '0;
      overflow_reg <= 1'b0;
    end else if (ld_start) begin
      wr_ptr_reg   <= '0;
      beat_reg     <= '0;
      overflow_reg <= 1'b0;
    end else if (loading) begin
      if (fire) begin
        asm_reg <= asm_next;
        if (last_beat) begin
          beat_reg   <= '0;
          wr_ptr_reg <= wr_ptr_reg + LEN_W'(1);
        end else begin
          beat_reg <= beat_reg + BEAT_W'(1);
        end
      end
      if (ld_end) begin
        beat_reg <= '0;
      end
    end else if (ld_valid && mem_full) begin
      overflow_reg <= 1'b1;
    end
  end

  prog_mem_array #(
    .DEPTH  (DEPTH),
    .INSTR_W(INSTR_W),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ld_start),
    .we    (word_we),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (asm_next),
    .raddr (address[AW-1:0]),
    .rdata (rd_word),
    .rvalid(rd_valid)
  );

  always_comb begin
    instruction = rd_word;
    if (loading || (int'(address) >= DEPTH) || !rd_valid) begin
      instruction = FILL;
    end
  end

  assign ld_ready = loading;
  assign cpu_hold = loading;
  assign prog_len = wr_ptr_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized bench for prog_mem_loader: three instances (LOAD_W = 4, 2, 3) share one word-level
// reference model and are driven with the same program stream, chunked for each port width.
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] address;
  logic       ld_start;
  logic       ld_end;
  logic [2:0] vld;
  logic [3:0] d4;
  logic [1:0] d2;
  logic [2:0] d3;
  logic [5:0] instr [3];
  logic [5:0] plen [3];
  logic [2:0] ready;
  logic [2:0] hold;
  logic [2:0] ovf;

  int n_cmp = 0;
  int n_err = 0;

  // Word-level reference model
  logic [5:0] mem_m [32];
  bit         valid_m [32];
  bit         loading_m;
  int         len_m;
  bit         ovf_m;

  always #5 clk = ~clk;

  prog_mem_loader #(.LOAD_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .address(address), .instruction(instr[0]),
    .ld_start(ld_start), .ld_valid(vld[0]), .ld_data(d4), .ld_end(ld_end),
    .ld_ready(ready[0]), .cpu_hold(hold[0]), .prog_len(plen[0]), .overflow(ovf[0])
  );

  prog_mem_loader #(.LOAD_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .address(address), .instruction(instr[1]),
    .ld_start(ld_start), .ld_valid(vld[1]), .ld_data(d2), .ld_end(ld_end),
    .ld_ready(ready[1]), .cpu_hold(hold[1]), .prog_len(plen[1]), .overflow(ovf[1])
  );

  prog_mem_loader #(.LOAD_W(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .address(address), .instruction(instr[2]),
    .ld_start(ld_start), .ld_valid(vld[2]), .ld_data(d3), .ld_end(ld_end),
    .ld_ready(ready[2]), .cpu_hold(hold[2]), .prog_len(plen[2]), .overflow(ovf[2])
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_read(input int a);
    if (loading_m || a >= 32 || !valid_m[a]) return 6'h3F;
    return mem_m[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld      = 3'b000;
    ld_start = 1'b0;
    ld_end   = 1'b0;
  endtask

  task automatic m_reset();
    loading_m = 0;
    len_m     = 0;
    ovf_m     = 0;
    for (int i = 0; i < 32; i++) valid_m[i] = 0;
  endtask

  task automatic m_start();
    m_reset();
    loading_m = 1;
  endtask

  task automatic m_chunk_idle();
    if (!loading_m && len_m == 32) ovf_m = 1;
  endtask

  task automatic m_word(input logic [5:0] w);
    if (loading_m) begin
      mem_m[len_m]   = w;
      valid_m[len_m] = 1;
      len_m++;
      if (len_m == 32) loading_m = 0;
    end else begin
      m_chunk_idle();
    end
  endtask

  task automatic read_all(input int a, input logic [5:0] expv);
    address = 8'(a);
    #1;
    for (int k = 0; k < 3; k++) check_value($sformatf("read%0d[%0h]", k, a), instr[k], expv);
  endtask

  task automatic check_all();
    int addrs [4];
    for (int k = 0; k < 3; k++) begin
      check_value($sformatf("hold%0d", k), hold[k], loading_m);
      check_value($sformatf("ready%0d", k), ready[k], loading_m);
      check_value($sformatf("prog_len%0d", k), plen[k], len_m);
      check_value($sformatf("overflow%0d", k), ovf[k], ovf_m);
    end
    addrs[0] = $urandom_range(0, 31);
    addrs[1] = $urandom_range(0, 255);
    addrs[2] = (len_m > 0) ? len_m - 1 : 0;
    addrs[3] = len_m;
    for (int i = 0; i < 4; i++) read_all(addrs[i], exp_read(addrs[i]));
  endtask

  // One random chunk on every port, as the opening beat of a word.
  task automatic drive_one_chunk();
    vld = 3'b111;
    d4  = 4'($urandom);
    d2  = 2'($urandom);
    d3  = 3'($urandom);
  endtask

  task automatic op_start(input bit with_valid);
    ld_start = 1'b1;
    if (with_valid) drive_one_chunk();
    tick();
    idle();
    m_start();
    $display("start valid=%0d", with_valid);
  endtask

  // Three cycles per word: the 2-bit port needs all three, the 4- and 3-bit ports only two.
  task automatic op_word(input logic [5:0] w, input bit with_end);
    logic [7:0] v4;
    v4 = {2'($urandom), w};
    for (int c = 0; c < 3; c++) begin
      vld = 3'b010;
      d2  = 2'(w >> (2 * (2 - c)));
      if (c < 2) begin
        vld[0] = 1'b1;
        vld[2] = 1'b1;
        d4 = 4'(v4 >> (4 * (1 - c)));
        d3 = 3'(w >> (3 * (1 - c)));
      end
      ld_end = with_end && (c == 2);
      tick();
    end
    idle();
    m_word(w);
    if (with_end) loading_m = 0;
    $display("word %02h end=%0d len=%0d", w, with_end, len_m);
  endtask

  task automatic op_end();
    ld_end = 1'b1;
    check_value("hold_before_end", hold[0], loading_m);
    tick();
    idle();
    loading_m = 0;
    $display("end len=%0d", len_m);
  endtask

  task automatic op_partial();
    drive_one_chunk();
    tick();
    idle();
    m_chunk_idle();
    ld_end = 1'b1;
    tick();
    idle();
    loading_m = 0;
    $display("partial+end len=%0d", len_m);
  endtask

  task automatic op_midstart();
    drive_one_chunk();
    tick();
    m_chunk_idle();
    ld_start = 1'b1;
    drive_one_chunk();
    tick();
    idle();
    m_start();
    $display("restart with coincident chunk");
  endtask

  task automatic op_reset();
    drive_one_chunk();
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_reset();
    $display("reset mid-word");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] w0;
    int r;
    rst_n   = 1'b0;
    address = 8'h00;
    d4 = '0; d2 = '0; d3 = '0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 6'h3F;
    tick();
    $display("reset released");
    check_all();
    read_all(0, 6'h3F);
    read_all(255, 6'h3F);

    // Three-word program
    op_start(0);
    op_word(6'h12, 0);
    op_word(6'h28, 0);
    op_word(6'h3B, 0);
    op_end();
    check_all();
    read_all(0, 6'h12);
    read_all(1, 6'h28);
    read_all(2, 6'h3B);
    read_all(3, 6'h3F);

    // Partial word discarded, then a reload clears the old program
    op_partial();
    check_all();
    op_start(0);
    check_all();
    op_end();
    check_all();
    read_all(0, 6'h3F);

    // Fill all 32 entries, auto-exit, then a chunk in IDLE flags overflow
    op_start(0);
    for (int i = 0; i < 32; i++) op_word(6'($urandom), 0);
    check_all();
    op_word(6'($urandom), 0);
    check_all();
    check_value("overflow_after_full", ovf[0], 1);
    read_all(40, 6'h3F);

    // Restart mid-load with a coincident chunk
    op_start(0);
    op_word(6'h05, 0);
    op_word(6'h0A, 0);
    op_midstart();
    check_all();
    op_word(6'h21, 0);
    op_end();
    check_all();
    read_all(0, 6'h21);
    read_all(1, 6'h3F);

    // Reset in the middle of a word
    op_start(0);
    op_word(6'h17, 0);
    op_reset();
    check_all();
    read_all(0, 6'h3F);

    // Randomized operation stream
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      op_start(0);
      else if (r < 15) op_start(1);
      else if (r < 70) begin
        w0 = 6'($urandom);
        op_word(w0, ($urandom_range(0, 9) == 0));
      end
      else if (r < 77) op_partial();
      else if (r < 84) op_midstart();
      else if (r < 94) op_end();
      else             op_reset();
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
